seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the datapath; takes over from the single-cycle combinational ALU.
//  Executes the same 13 opcodes with a start/done handshake.
//  MUL is an iterative radix-4 Booth multiplier; DIV is an iterative signed restoring divider.
//  Result is split into HI/LO for the HI/LO registers; the control unit stalls on busy.
// PARAMETERS
//  WIDTH   32   operand width (even, >=8); HI/LO each WIDTH bits
//  SHW     $clog2(WIDTH)   shift/rotate amount bits taken from rb[SHW-1:0]
// PORTS
//  clock      in   1      rising-edge clock
//  clear      in   1      reset: asynchronous, active-high
//  start      in   1      request; accepted only when busy=0
//  opcode     in   5      operation, sampled at accept
//  ra         in   WIDTH  operand A, sampled at accept
//  rb         in   WIDTH  operand B / shift amount, sampled at accept
//  busy       out  1      high from the cycle after accept until done
//  done       out  1      one-cycle pulse when hi/lo/flags update
//  hi         out  WIDTH  MUL: upper product; DIV: remainder; other ops: sign extension of lo
//  lo         out  WIDTH  MUL: lower product; DIV: quotient; other ops: result
//  div_zero   out  1      DIV with rb==0; valid with done, held until next done
//  bad_op     out  1      unassigned opcode; valid with done, held until next done
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, div_zero and bad_op are 0; hi and lo are 0. clear mid-operation aborts with no done pulse.
//  Opcodes: add 00000, sub 00001, mul 00010, div 00011, and 00100, or 00101, shr 00110, shra 00111,
//   shl 01000, ror 01001, rol 01011, neg 01100, not 01101. All other codes: lo=0, hi=0, bad_op=1.
//  Accept: start && !busy at edge T latches opcode, ra and rb. start while busy is ignored; there is no queueing.
//  Single-cycle ops: done=1 at T+1 with results; busy stays 0; back-to-back accept is allowed every cycle.
//  FSM states: IDLE, MUL_IT, DIV_IT, DIV_FIX.
//   IDLE -> MUL_IT (mul) or DIV_IT (div, rb!=0); otherwise stays in IDLE.
//   MUL_IT: WIDTH/2 radix-4 Booth steps on a 2*WIDTH+1 accumulator, then -> IDLE with done.
//   MUL latency: done at T+WIDTH/2+1.
//   DIV_IT: WIDTH restoring steps on the operand magnitudes, then -> DIV_FIX.
//   DIV_FIX: apply signs, then -> IDLE with done. DIV latency: done at T+WIDTH+2.
//  Arithmetic:
//   add/sub/neg wrap modulo 2^WIDTH; there is no carry output.
//   mul is signed x signed with the full 2*WIDTH-bit product; most-negative x most-negative is exact.
//   div quotient truncates toward zero; remainder takes the dividend's sign.
//   div of most-negative by -1 gives lo=most-negative, hi=0.
//   div with rb==0: no iteration, done at T+1, lo=all ones, hi=ra, div_zero=1.
//   Shifts and rotates use rb[SHW-1:0] only (amount mod WIDTH); shra fills with ra's MSB.
//  hi/lo/flags change only on a done cycle and hold otherwise. done is never high for 2 consecutive cycles from a single multi-cycle op.
// STRUCTURE
//  alu_pkg: opcode localparams, FSM state encoding, and function booth_r4_digit(3-bit) -> {-2..+2}.
//  seq_alu instantiates sub-module seq_div_unit (WIDTH param; start/abs operands in, quotient/remainder magnitudes + done out).
//  The Booth iteration and the single-cycle ops stay inline in seq_alu.
// TESTING (WIDTH=32)
//  1 add 0x7FFFFFFF+1 -> done at T+1, lo=0x80000000, hi=0xFFFFFFFF; then and/or/not/neg sweep back-to-back every cycle.
//  2 mul -7*5 -> done at T+17, hi=0xFFFFFFFF, lo=0xFFFFFFDD; mul 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  3 div -17/5 -> done at T+34, lo=0xFFFFFFFD, hi=0xFFFFFFFE; div 9/0 -> done T+1, div_zero=1, lo=0xFFFFFFFF, hi=9.
//  4 ror 0x80000001 by 1 -> lo=0xC0000000; shl 1 by 33 -> lo=2; shra 0x80000000 by 4 -> lo=0xF8000000.
//  5 start pulsed during mul busy with new operands -> ignored; the original product is returned; opcode 11111 -> bad_op=1, lo=0.
//  6 clear asserted at T+5 of div -> busy=0 and hi/lo=0 immediately with no done; a new add accepted next cycle completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode encodings, FSM states and radix-4 Booth recoding shared by the sequential ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_SHR  = 5'b00110;
    localparam logic [4:0] OP_SHRA = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_IT,
        ST_DIV_IT,
        ST_DIV_FIX
    } state_t;

    // Maps multiplier bits {b[2i+1], b[2i], b[2i-1]} to a digit in -2..+2.
    function automatic logic signed [2:0] booth_r4_digit(input logic [2:0] bits);
        logic signed [2:0] d;
        case (bits)
            3'b001, 3'b010: d = 3'sb001;
            3'b011:         d = 3'sb010;
            3'b100:         d = 3'sb110;
            3'b101, 3'b110: d = 3'sb111;
            default:        d = 3'sb000;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seq_div_unit.sv
// Unsigned restoring divider on operand magnitudes, one quotient bit per cycle.
// Latency: done pulses WIDTH cycles after start; results hold until the next start.
// Backpressure: none; start is only issued by the owner while the unit is idle.
module seq_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH:0]   r_sh;
    logic             fits;

    // Quotient register doubles as the dividend shifter; its MSB feeds the partial remainder.
    assign r_sh = {remainder, quotient[WIDTH-1]};
    assign fits = r_sh >= {1'b0, dvs_q};

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            quotient  <= '0;
            remainder <= '0;
            dvs_q     <= '0;
            cnt       <= '0;
            run       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient  <= dividend;
                remainder <= '0;
                dvs_q     <= divisor;
                cnt       <= '0;
                run       <= 1'b1;
            end else if (run) begin
                remainder <= fits ? (r_sh[WIDTH-1:0] - dvs_q) : r_sh[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], fits};
                cnt       <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: 13 ops, radix-4 Booth MUL, signed restoring DIV, HI/LO result.
// Latency: 1 cycle for simple ops and div-by-zero, WIDTH/2+1 for MUL, WIDTH+2 for DIV.
// Backpressure: busy high during MUL/DIV; start while busy is dropped, not queued.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             bad_op
);

    localparam int            CW  = $clog2(WIDTH/2 + 1);
    localparam int            AW  = 2*WIDTH + 1;
    localparam logic [SHW:0]  WSH = WIDTH;

    state_t state, state_nxt;

    logic             accept, is_mul, is_div, div_start, div_done;
    logic             pend, mul_last, a_neg, b_neg;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, mcand, div_q, div_r, abs_a, abs_b;
    logic [AW-1:0]    acc, acc_step;
    logic [CW-1:0]    mul_cnt;

    assign busy      = (state != ST_IDLE);
    assign accept    = start && !busy;
    assign is_mul    = (opcode == OP_MUL);
    assign is_div    = (opcode == OP_DIV) && (rb != '0);
    assign div_start = accept && is_div;
    assign mul_last  = (mul_cnt == CW'(WIDTH/2));
    assign abs_a     = ra[WIDTH-1] ? -ra : ra;
    assign abs_b     = rb[WIDTH-1] ? -rb : rb;

    seq_div_unit #(.WIDTH(WIDTH)) u_div (
        .clock     (clock),
        .clear     (clear),
        .start     (div_start),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_mul) state_nxt = ST_MUL_IT;
                else if (div_start)   state_nxt = ST_DIV_IT;
            end
            ST_MUL_IT:  if (mul_last) state_nxt = ST_IDLE;
            ST_DIV_IT:  if (div_done) state_nxt = ST_DIV_FIX;
            ST_DIV_FIX: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // One Booth step: add digit*multiplicand to the upper part (2 guard bits), then shift right 2.
    logic signed [2:0] digit;
    logic [WIDTH+1:0]  m_ext, pp, psum;

    always_comb begin
        digit = booth_r4_digit(acc[2:0]);
        m_ext = {{2{mcand[WIDTH-1]}}, mcand};
        case (digit)
            3'sb001: pp = m_ext;
            3'sb010: pp = m_ext << 1;
            3'sb111: pp = -m_ext;
            3'sb110: pp = -(m_ext << 1);
            default: pp = '0;
        endcase
        psum     = {{2{acc[AW-1]}}, acc[AW-1:WIDTH+1]} + pp;
        acc_step = {psum, acc[WIDTH:2]};
    end

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_dz, sc_bad;

    // Only div-by-zero reaches the single-cycle path for OP_DIV.
    always_comb begin
        sh     = b_q[SHW-1:0];
        sc_lo  = '0;
        sc_dz  = 1'b0;
        sc_bad = 1'b0;
        case (op_q)
            OP_ADD:  sc_lo = a_q + b_q;
            OP_SUB:  sc_lo = a_q - b_q;
            OP_DIV:  begin sc_lo = '1; sc_dz = 1'b1; end
            OP_AND:  sc_lo = a_q & b_q;
            OP_OR:   sc_lo = a_q | b_q;
            OP_SHR:  sc_lo = a_q >> sh;
            OP_SHRA: sc_lo = $signed(a_q) >>> sh;
            OP_SHL:  sc_lo = a_q << sh;
            OP_ROR:  sc_lo = (a_q >> sh) | (a_q << (WSH - {1'b0, sh}));
            OP_ROL:  sc_lo = (a_q << sh) | (a_q >> (WSH - {1'b0, sh}));
            OP_NEG:  sc_lo = -a_q;
            OP_NOT:  sc_lo = ~a_q;
            default: sc_bad = 1'b1;
        endcase
        sc_hi = (op_q == OP_DIV) ? a_q : {WIDTH{sc_lo[WIDTH-1]}};
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            pend     <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand    <= '0;
            acc      <= '0;
            mul_cnt  <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            bad_op   <= 1'b0;
        end else begin
            done <= 1'b0;
            pend <= accept && !is_mul && !is_div;
            if (accept) begin
                op_q    <= opcode;
                a_q     <= ra;
                b_q     <= rb;
                mcand   <= ra;
                acc     <= {{WIDTH{1'b0}}, rb, 1'b0};
                mul_cnt <= '0;
                a_neg   <= ra[WIDTH-1];
                b_neg   <= rb[WIDTH-1];
            end else if (state == ST_MUL_IT && !mul_last) begin
                acc     <= acc_step;
                mul_cnt <= mul_cnt + 1'b1;
            end

            if (pend) begin
                hi       <= sc_hi;
                lo       <= sc_lo;
                div_zero <= sc_dz;
                bad_op   <= sc_bad;
                done     <= 1'b1;
            end else if (state == ST_MUL_IT && mul_last) begin
                hi       <= acc[AW-1:WIDTH+1];
                lo       <= acc[WIDTH:1];
                div_zero <= 1'b0;
                bad_op   <= 1'b0;
                done     <= 1'b1;
            end else if (state == ST_DIV_FIX) begin
                lo       <= (a_neg ^ b_neg) ? -div_q : div_q;
                hi       <= a_neg ? -div_r : div_r;
                div_zero <= 1'b0;
                bad_op   <= 1'b0;
                done     <= 1'b1;
            end
        end
    end

endmodule
